text_write_scheduler: RTL and testbench
=======================================

// Module: text_write_scheduler
// PURPOSE
//  Sole owner of the text RAM write port (text_wr_ena/addr/data) feeding text_pixel_generator.
//  Arbitrates three writers: random-address host writes, a cursor-based character stream,
//  and an internal screen-fill engine (clear/fill screen with one character code).
//  Fill has exclusive ownership while active; host and stream share the port round-robin.
// PARAMETERS
//  TEXT_WIDTH   60                        characters per text row
//  TEXT_HEIGHT  20                        text rows per screen
//  TEXT_LEN     TEXT_WIDTH*TEXT_HEIGHT    character cells; last valid address = TEXT_LEN-1
//  ADDR_W       13                        text RAM address width (TEXT_LEN <= 2**ADDR_W)
// PORTS
//  clk              in   1       single clock; write port runs on it (clk_text_wr = clk)
//  reset            in   1       synchronous, active-high
//  host_wr_valid    in   1       host random write request
//  host_wr_ready    out  1       host write accepted this cycle (valid&&ready)
//  host_wr_addr     in   ADDR_W  target cell
//  host_wr_data     in   8       character code
//  strm_valid       in   1       cursor-stream character request
//  strm_ready       out  1       stream character accepted this cycle
//  strm_data        in   8       character code, written at cursor
//  cursor_set       in   1       load cursor (1-cycle pulse)
//  cursor_set_addr  in   ADDR_W  new cursor value
//  cursor_addr      out  ADDR_W  current cursor
//  fill_start       in   1       start screen fill (1-cycle pulse)
//  fill_char        in   8       fill character, sampled with fill_start
//  fill_busy        out  1       fill in progress
//  fill_done        out  1       1-cycle pulse, last fill write on port
//  text_wr_ena      out  1       to text RAM wren
//  text_wr_addr     out  ADDR_W  to text RAM wraddress
//  text_wr_data     out  8       to text RAM data
// BEHAVIOUR
//  - Reset: all outputs 0 (readies forced 0 while reset high); FSM=IDLE; cursor=0; RR pointer
//    favours host. Reset mid-fill aborts fill; no fill_done pulse.
//  - FSM IDLE/FILL. IDLE: fill_start -> FILL next cycle, latch fill_char, fill_cnt=0; no
//    host/strm accept in the fill_start cycle. FILL: one write per cycle, addr=fill_cnt,
//    fill_cnt++; after issuing TEXT_LEN-1 -> IDLE. fill_start in FILL ignored.
//  - fill_busy=1 exactly while FSM=FILL (TEXT_LEN cycles). Both readies 0 in FILL.
//  - Arbitration (IDLE, no fill_start): ready asserted only to a valid requester; one grant
//    per cycle. Both valid -> grant the one not granted last; RR pointer updates on grant only.
//    Readies are combinational from valids/state; write-port outputs are registered.
//  - Latency: accepted request in cycle N -> text_wr_ena=1 with its addr/data in cycle N+1.
//    No accept -> text_wr_ena=0 next cycle, addr/data hold previous values.
//  - Host addr >= TEXT_LEN: handshake completes, write dropped (text_wr_ena stays 0).
//  - Stream write uses cursor_addr; cursor then increments, TEXT_LEN-1 wraps to 0.
//  - cursor_set: cursor=cursor_set_addr next cycle (>= TEXT_LEN loads 0); overrides stream
//    increment in same cycle, but that cycle's stream write still uses the old cursor.
//  - Fill completion sets cursor=0 (same cycle FSM returns to IDLE), overriding cursor_set.
//  - fill_done coincides with the registered write of address TEXT_LEN-1.
// TESTING
//  - Host only: write (addr 5, 8'h41) -> ready same cycle; ena=1, addr=5, data=41 next cycle.
//  - Both valid held 4 cycles -> grants host,strm,host,strm; writes to 7,cur0,7,cur0+1.
//  - Stream 1201 chars from cursor 0 (60x20) -> addrs 0..1199 then 0; cursor_addr ends 1.
//  - fill_start char 8'h20 -> 1200 consecutive writes addr 0..1199, fill_busy 1200 cycles,
//    fill_done with addr 1199, readies 0 throughout, cursor_addr=0 afterwards.
//  - Reset asserted at fill write 300 -> next cycle ena=0, busy=0, no done; host write works.
//  - Host addr 1200 -> accepted, no write; cursor_set 4000 -> cursor_addr=0.

Source files
------------

// File: rtl/text_write_scheduler.sv
// -----------------------------------------------------------------------------
// text_write_scheduler
//   The only driver of the text RAM write port that feeds text_pixel_generator.
//   Three sources compete for that port:
//     * host   - random-address writes (valid/ready)
//     * stream - characters written at an auto-incrementing cursor (valid/ready)
//     * fill   - internal engine that writes one character code to every cell
//   While a fill runs it owns the port exclusively. Otherwise host and stream
//   share the port round-robin, with at most one grant per cycle.
//
// Ports
//   clk, reset                      single clock, synchronous active-high reset
//   host_wr_valid/ready/addr/data   host write channel
//   strm_valid/ready/data           cursor stream channel
//   cursor_set, cursor_set_addr     cursor load pulse and its value
//   cursor_addr                     current cursor
//   fill_start, fill_char           fill trigger pulse and its character
//   fill_busy, fill_done            fill in progress / pulse with the last fill write
//   text_wr_ena/addr/data           registered text RAM write port
// -----------------------------------------------------------------------------
module text_write_scheduler #(
  parameter int TEXT_WIDTH  = 60,
  parameter int TEXT_HEIGHT = 20,
  parameter int TEXT_LEN    = TEXT_WIDTH * TEXT_HEIGHT,
  parameter int ADDR_W      = 13
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              host_wr_valid,
  output logic              host_wr_ready,
  input  logic [ADDR_W-1:0] host_wr_addr,
  input  logic [7:0]        host_wr_data,
  input  logic              strm_valid,
  output logic              strm_ready,
  input  logic [7:0]        strm_data,
  input  logic              cursor_set,
  input  logic [ADDR_W-1:0] cursor_set_addr,
  output logic [ADDR_W-1:0] cursor_addr,
  input  logic              fill_start,
  input  logic [7:0]        fill_char,
  output logic              fill_busy,
  output logic              fill_done,
  output logic              text_wr_ena,
  output logic [ADDR_W-1:0] text_wr_addr,
  output logic [7:0]        text_wr_data
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(TEXT_LEN - 1);
  localparam logic [ADDR_W-1:0] ZERO_ADDR = {ADDR_W{1'b0}};

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_FILL = 1'b1
  } state_t;

  state_t            state_r,     state_s;
  logic [ADDR_W-1:0] fill_cnt_r,  fill_cnt_s;
  logic [7:0]        fill_char_r, fill_char_s;
  logic [ADDR_W-1:0] cursor_r,    cursor_s;
  // 1: host wins the next tie, 0: stream wins it
  logic              rr_host_r,   rr_host_s;
  logic              wr_ena_r,    wr_ena_s;
  logic [ADDR_W-1:0] wr_addr_r,   wr_addr_s;
  logic [7:0]        wr_data_r,   wr_data_s;
  logic              fill_done_r, fill_done_s;
  logic              fill_busy_r;
  logic              host_grant_s;
  logic              strm_grant_s;

  assign host_wr_ready = host_grant_s;
  assign strm_ready    = strm_grant_s;
  assign cursor_addr   = cursor_r;
  assign fill_busy     = fill_busy_r;
  assign fill_done     = fill_done_r;
  assign text_wr_ena   = wr_ena_r;
  assign text_wr_addr  = wr_addr_r;
  assign text_wr_data  = wr_data_r;

  // Next-state, arbitration and next write-port values.
  always_comb begin
    state_s      = state_r;
    fill_cnt_s   = fill_cnt_r;
    fill_char_s  = fill_char_r;
    rr_host_s    = rr_host_r;
    host_grant_s = 1'b0;
    strm_grant_s = 1'b0;
    wr_ena_s     = 1'b0;
    wr_addr_s    = wr_addr_r;   // address/data hold when nothing is written
    wr_data_s    = wr_data_r;
    fill_done_s  = 1'b0;
    cursor_s     = cursor_r;

    case (state_r)
      ST_IDLE: begin
        if (reset) begin
          // readies must stay low while reset is held
          state_s = ST_IDLE;
        end else if (fill_start) begin
          // the fill_start cycle grants nobody
          state_s     = ST_FILL;
          fill_char_s = fill_char;
          fill_cnt_s  = ZERO_ADDR;
        end else if (host_wr_valid && strm_valid) begin
          host_grant_s = rr_host_r;
          strm_grant_s = ~rr_host_r;
        end else begin
          host_grant_s = host_wr_valid;
          strm_grant_s = strm_valid;
        end
      end
      ST_FILL: begin
        wr_ena_s  = 1'b1;
        wr_addr_s = fill_cnt_r;
        wr_data_s = fill_char_r;
        if (fill_cnt_r == LAST_ADDR) begin
          state_s     = ST_IDLE;
          fill_cnt_s  = ZERO_ADDR;
          fill_done_s = 1'b1;
        end else begin
          fill_cnt_s  = fill_cnt_r + ADDR_W'(1);
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase

    if (host_grant_s) begin
      rr_host_s = 1'b0;
      // out-of-range host writes complete the handshake but never reach the RAM
      if (host_wr_addr <= LAST_ADDR) begin
        wr_ena_s  = 1'b1;
        wr_addr_s = host_wr_addr;
        wr_data_s = host_wr_data;
      end else begin
        wr_ena_s  = 1'b0;
      end
    end else if (strm_grant_s) begin
      rr_host_s = 1'b1;
      wr_ena_s  = 1'b1;
      wr_addr_s = cursor_r;
      wr_data_s = strm_data;
    end else begin
      rr_host_s = rr_host_r;
    end

    // Priority: fill completion > cursor load > stream increment.
    // The stream write above already used the old cursor.
    if (fill_done_s) begin
      cursor_s = ZERO_ADDR;
    end else if (cursor_set) begin
      cursor_s = (cursor_set_addr <= LAST_ADDR) ? cursor_set_addr : ZERO_ADDR;
    end else if (strm_grant_s) begin
      cursor_s = (cursor_r == LAST_ADDR) ? ZERO_ADDR : cursor_r + ADDR_W'(1);
    end else begin
      cursor_s = cursor_r;
    end
  end

  // State, cursor and registered write-port outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      fill_cnt_r  <= ZERO_ADDR;
      fill_char_r <= 8'h00;
      cursor_r    <= ZERO_ADDR;
      rr_host_r   <= 1'b1;
      wr_ena_r    <= 1'b0;
      wr_addr_r   <= ZERO_ADDR;
      wr_data_r   <= 8'h00;
      fill_done_r <= 1'b0;
      fill_busy_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      fill_cnt_r  <= fill_cnt_s;
      fill_char_r <= fill_char_s;
      cursor_r    <= cursor_s;
      rr_host_r   <= rr_host_s;
      wr_ena_r    <= wr_ena_s;
      wr_addr_r   <= wr_addr_s;
      wr_data_r   <= wr_data_s;
      fill_done_r <= fill_done_s;
      fill_busy_r <= (state_s == ST_FILL);
    end
  end

endmodule

// File: tb/tb_text_write_scheduler.sv
// -----------------------------------------------------------------------------
// tb_text_write_scheduler
//   Randomised bench for text_write_scheduler. A behavioural model decides, for
//   every cycle, which requester should be granted and pushes the expected RAM
//   writes (tagged with the cycle they must appear in) into a queue. A monitor
//   on the falling edge pops and compares whenever the write port is active.
// -----------------------------------------------------------------------------
module tb_text_write_scheduler;

  localparam int TEXT_LEN = 1200;
  localparam int ADDR_W   = 13;

  logic              clk = 1'b0;
  logic              reset;
  logic              host_wr_valid;
  logic              host_wr_ready;
  logic [ADDR_W-1:0] host_wr_addr;
  logic [7:0]        host_wr_data;
  logic              strm_valid;
  logic              strm_ready;
  logic [7:0]        strm_data;
  logic              cursor_set;
  logic [ADDR_W-1:0] cursor_set_addr;
  logic [ADDR_W-1:0] cursor_addr;
  logic              fill_start;
  logic [7:0]        fill_char;
  logic              fill_busy;
  logic              fill_done;
  logic              text_wr_ena;
  logic [ADDR_W-1:0] text_wr_addr;
  logic [7:0]        text_wr_data;

  text_write_scheduler dut (
    .clk             (clk),
    .reset           (reset),
    .host_wr_valid   (host_wr_valid),
    .host_wr_ready   (host_wr_ready),
    .host_wr_addr    (host_wr_addr),
    .host_wr_data    (host_wr_data),
    .strm_valid      (strm_valid),
    .strm_ready      (strm_ready),
    .strm_data       (strm_data),
    .cursor_set      (cursor_set),
    .cursor_set_addr (cursor_set_addr),
    .cursor_addr     (cursor_addr),
    .fill_start      (fill_start),
    .fill_char       (fill_char),
    .fill_busy       (fill_busy),
    .fill_done       (fill_done),
    .text_wr_ena     (text_wr_ena),
    .text_wr_addr    (text_wr_addr),
    .text_wr_data    (text_wr_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests_run    = 0;
  int tests_failed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    int                cyc;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data;
    logic              done;
  } exp_t;

  exp_t exp_q[$];

  // reference model state
  int  m_cursor      = 0;
  bit  m_last_strm   = 1'b1;   // host wins the first tie
  bit  m_fill_active = 1'b0;
  int  m_fill_end    = 0;

  // monitor: every write must match the head of the queue in the right cycle
  bit                mon_en    = 1'b0;
  logic [ADDR_W-1:0] hold_addr = '0;
  logic [7:0]        hold_data = 8'h00;

  always @(negedge clk) begin
    if (mon_en) begin
      if (text_wr_ena === 1'b1) begin
        if (exp_q.size() == 0) begin
          tests_run++;
          tests_failed++;
          $display("FAIL unexpected_write: got addr %0d data %0h, expected no write (cycle %0d)",
                   text_wr_addr, text_wr_data, cyc);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("wr_cycle", cyc, e.cyc);
          check("wr_addr", text_wr_addr, e.addr);
          check("wr_data", text_wr_data, e.data);
          check("fill_done", fill_done, e.done);
          hold_addr = e.addr;
          hold_data = e.data;
        end
      end else begin
        check("wr_ena_low", text_wr_ena, 1'b0);
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
          exp_t e;
          e = exp_q.pop_front();
          tests_run++;
          tests_failed++;
          $display("FAIL missing_write: got none, expected addr %0d data %0h at cycle %0d",
                   e.addr, e.data, e.cyc);
        end
        check("hold_addr", text_wr_addr, hold_addr);
        check("hold_data", text_wr_data, hold_data);
        check("fill_done_idle", fill_done, 1'b0);
      end
      if (reset === 1'b1) begin
        hold_addr = '0;
        hold_data = 8'h00;
      end
    end
  end

  // One clock cycle: drive inputs, check readies/cursor/busy against the model,
  // enqueue the expected writes, then advance to just after the next edge.
  task automatic step(input logic hv, input logic [ADDR_W-1:0] ha, input logic [7:0] hd,
                      input logic sv, input logic [7:0] sd,
                      input logic cs, input logic [ADDR_W-1:0] csa,
                      input logic fs, input logic [7:0] fc, input logic rst);
    bit eh, es, fill_complete;
    int new_cur;
    reset = rst; host_wr_valid = hv; host_wr_addr = ha; host_wr_data = hd;
    strm_valid = sv; strm_data = sd; cursor_set = cs; cursor_set_addr = csa;
    fill_start = fs; fill_char = fc;
    #1;
    eh = 1'b0; es = 1'b0; fill_complete = 1'b0;
    if (!rst && !m_fill_active && !fs) begin
      if (hv && sv) begin
        eh = m_last_strm;
        es = !m_last_strm;
      end else begin
        eh = hv;
        es = sv;
      end
    end
    check("host_ready", host_wr_ready, eh);
    check("strm_ready", strm_ready, es);
    check("cursor", cursor_addr, m_cursor);
    check("fill_busy", fill_busy, m_fill_active);

    if (rst) begin
      while (exp_q.size() > 0 && exp_q[$].cyc > cyc) void'(exp_q.pop_back());
      m_fill_active = 1'b0;
      m_cursor      = 0;
      m_last_strm   = 1'b1;
    end else begin
      if (m_fill_active) begin
        if (cyc == m_fill_end) begin
          m_fill_active = 1'b0;
          fill_complete = 1'b1;
        end
      end else if (fs) begin
        m_fill_active = 1'b1;
        m_fill_end    = cyc + TEXT_LEN;
        for (int i = 0; i < TEXT_LEN; i++)
          exp_q.push_back('{cyc + 2 + i, ADDR_W'(i), fc, (i == TEXT_LEN - 1)});
      end
      new_cur = m_cursor;
      if (eh) begin
        m_last_strm = 1'b0;
        if (ha < TEXT_LEN) exp_q.push_back('{cyc + 1, ha, hd, 1'b0});
      end
      if (es) begin
        m_last_strm = 1'b1;
        exp_q.push_back('{cyc + 1, ADDR_W'(m_cursor), sd, 1'b0});
        new_cur = (m_cursor + 1) % TEXT_LEN;
      end
      if (cs) new_cur = (csa < TEXT_LEN) ? int'(csa) : 0;
      if (fill_complete) new_cur = 0;
      m_cursor = new_cur;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, '0, 8'h00, 1'b0, 8'h00, 1'b0, '0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic rand_step(input bit allow_fs);
    step(1'($urandom_range(0, 1)), ADDR_W'($urandom_range(0, 1299)), 8'($urandom_range(0, 255)),
         1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
         ($urandom_range(0, 9) == 0), ADDR_W'($urandom_range(0, 8191)),
         allow_fs && ($urandom_range(0, 49) == 0), 8'hAA, 1'b0);
  endtask

  initial begin
    reset = 1'b1; host_wr_valid = 1'b1; host_wr_addr = '0; host_wr_data = 8'h00;
    strm_valid = 1'b1; strm_data = 8'h00; cursor_set = 1'b0; cursor_set_addr = '0;
    fill_start = 1'b0; fill_char = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_host_ready", host_wr_ready, 1'b0);
    check("rst_strm_ready", strm_ready, 1'b0);
    check("rst_wr_ena", text_wr_ena, 1'b0);
    check("rst_wr_addr", text_wr_addr, 0);
    check("rst_wr_data", text_wr_data, 0);
    check("rst_cursor", cursor_addr, 0);
    check("rst_fill_busy", fill_busy, 1'b0);
    check("rst_fill_done", fill_done, 1'b0);
    mon_en = 1'b1;

    // both requesters held: host, stream, host, stream
    for (int i = 0; i < 4; i++)
      step(1'b1, 13'd7, 8'(8'h50 + i), 1'b1, 8'(8'h60 + i), 1'b0, '0, 1'b0, 8'h00, 1'b0);
    // host only
    step(1'b1, 13'd5, 8'h41, 1'b0, 8'h00, 1'b0, '0, 1'b0, 8'h00, 1'b0);
    idle();
    // out-of-range cursor load and host address
    step(1'b0, '0, 8'h00, 1'b0, 8'h00, 1'b1, 13'd4000, 1'b0, 8'h00, 1'b0);
    step(1'b1, 13'd1200, 8'h33, 1'b0, 8'h00, 1'b0, '0, 1'b0, 8'h00, 1'b0);
    idle();
    check("cursor_after_set_4000", cursor_addr, 0);

    for (int i = 0; i < 400; i++) rand_step(1'b0);

    // stream 1201 characters from cursor 0: wraps once
    step(1'b0, '0, 8'h00, 1'b0, 8'h00, 1'b1, 13'd0, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 1201; i++)
      step(1'b0, '0, 8'h00, 1'b1, 8'($urandom_range(0, 255)), 1'b0, '0, 1'b0, 8'h00, 1'b0);
    idle();
    check("cursor_after_stream", cursor_addr, 1);

    // full-screen fill with spaces under random traffic
    step(1'b0, '0, 8'h00, 1'b0, 8'h00, 1'b0, '0, 1'b1, 8'h20, 1'b0);
    for (int i = 0; i < 1205; i++) rand_step(i < 1190);
    check("cursor_after_fill_traffic", cursor_addr, m_cursor);

    // a clean fill, then check cursor
    step(1'b0, '0, 8'h00, 1'b0, 8'h00, 1'b0, '0, 1'b1, 8'h2E, 1'b0);
    for (int i = 0; i < 1202; i++) idle();
    check("cursor_after_fill", cursor_addr, 0);

    // reset while fill write 300 is on the port
    step(1'b0, '0, 8'h00, 1'b0, 8'h00, 1'b0, '0, 1'b1, 8'h2A, 1'b0);
    for (int i = 0; i < 301; i++)
      step(1'($urandom_range(0, 1)), 13'd9, 8'h11, 1'($urandom_range(0, 1)), 8'h22,
           1'b0, '0, 1'b0, 8'h00, 1'b0);
    step(1'b1, 13'd9, 8'h11, 1'b1, 8'h22, 1'b0, '0, 1'b0, 8'h00, 1'b1);
    idle();
    check("busy_after_reset", fill_busy, 1'b0);
    step(1'b1, 13'd100, 8'h55, 1'b0, 8'h00, 1'b0, '0, 1'b0, 8'h00, 1'b0);
    idle();

    for (int i = 0; i < 300; i++) rand_step(1'b0);
    repeat (3) idle();
    check("queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
